// File: rtl/pending_priority_encoder_if.sv
// Request/grant bundle for pending_priority_encoder.
// slave is the encoder side; master is the event-source and consumer side.
interface pending_priority_encoder_if #(
    parameter int N  = 8,
    parameter int QW = 3
);
    logic [N-1:0]  D;
    logic          EN;
    logic          READY;
    logic [QW-1:0] Q;
    logic          V;
    logic [N-1:0]  PEND;
    logic          OVF;

    modport master (output D, EN, READY, input Q, V, PEND, OVF);
    modport slave  (input D, EN, READY, output Q, V, PEND, OVF);
endinterface

// File: rtl/pending_priority_encoder.sv
// Captures request events into a pending vector and presents them one index at a time.
// Handshake: Q transfers on a rising edge where V=1 and READY=1; Q/V never change while V=1 and READY=0.
module pending_priority_encoder #(
    parameter int N    = 8,
    parameter int QW   = 3,
    parameter int MODE = 0
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    pending_priority_encoder_if.slave   bus
);

    logic [N-1:0]   r_pend;
    logic [QW-1:0]  r_q;
    logic [QW-1:0]  r_last;
    logic           r_v;
    logic           r_ovf;

    logic           w_acc;
    logic           w_load;
    logic [N-1:0]   w_q_oh;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_hold;
    logic [N-1:0]   w_cand;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [QW-1:0]  w_sel;
    logic           w_found;
    int             w_sum;

    assign w_q_oh = {{(N-1){1'b0}}, 1'b1} << r_q;
    assign w_acc  = r_v & bus.READY;
    assign w_clr  = w_acc ? w_q_oh : '0;
    assign w_hold = (r_v & ~w_acc) ? w_q_oh : '0;
    assign w_cand = r_pend & ~w_clr & ~w_hold;
    assign w_load = ~r_v | w_acc;

    // Bit k of w_rot is candidate index (r_last + 1 + k) mod N.
    assign w_dbl = {w_cand, w_cand} >> (int'(r_last) + 1);
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (w_cand[i]) begin
                    w_sel   = QW'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (w_rot[k]) begin
                    w_sum = int'(r_last) + 1 + k;
                    if (w_sum >= N) w_sum = w_sum - N;
                    w_sel   = w_sum[QW-1:0];
                    w_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend <= '0;
            r_q    <= '0;
            r_v    <= 1'b0;
            r_ovf  <= 1'b0;
            r_last <= QW'(N - 1);
        end else begin
            // New events win over the clear of the accepted bit.
            r_pend <= (r_pend & ~w_clr) | bus.D;
            r_ovf  <= |(bus.D & r_pend & ~w_clr);
            if (w_acc) r_last <= r_q;
            if (w_load) begin
                if (bus.EN && w_found) begin
                    r_q <= w_sel;
                    r_v <= 1'b1;
                end else begin
                    r_v <= 1'b0;
                end
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.V    = r_v;
    assign bus.PEND = r_pend;
    assign bus.OVF  = r_ovf;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Runs a fixed-priority and a round-robin instance on shared stimulus against a behavioural model.
module tb_pending_priority_encoder;
    localparam int N  = 8;
    localparam int QW = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] drv_d;
    logic         drv_en;
    logic         drv_ready;

    int n_chk = 0;
    int n_err = 0;

    bit [N-1:0] m_pend [2];
    bit         m_v    [2];
    int         m_q    [2];
    int         m_last [2];
    bit         m_ovf  [2];

    pending_priority_encoder_if #(.N(N), .QW(QW)) if0 ();
    pending_priority_encoder_if #(.N(N), .QW(QW)) if1 ();

    assign if0.D = drv_d;  assign if0.EN = drv_en;  assign if0.READY = drv_ready;
    assign if1.D = drv_d;  assign if1.EN = drv_en;  assign if1.READY = drv_ready;

    pending_priority_encoder #(.N(N), .QW(QW), .MODE(0)) dut0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
    pending_priority_encoder #(.N(N), .QW(QW), .MODE(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_v[m] = 1'b0; m_q[m] = 0; m_ovf[m] = 1'b0; m_last[m] = N - 1;
        end
    endtask

    // m=0: highest index first; m=1: smallest upward distance from last accepted index.
    task automatic model_step(input int m);
        bit acc, ov;
        bit [N-1:0] nxt;
        int cand[$];
        int best, best_key, key, old_q;
        acc   = m_v[m] && drv_ready;
        old_q = m_q[m];
        ov    = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit p;
            p = m_pend[m][i] && !(acc && i == old_q);
            if (drv_d[i] && p) ov = 1'b1;
            if (p && !(m_v[m] && !acc && i == old_q)) cand.push_back(i);
            nxt[i] = p || drv_d[i];
        end
        if (!m_v[m] || acc) begin
            if (drv_en && cand.size() > 0) begin
                best = cand[0];
                best_key = N;
                foreach (cand[j]) begin
                    key = (m == 0) ? (N - 1 - cand[j]) : ((cand[j] - m_last[m] - 1 + 2 * N) % N);
                    if (key < best_key) begin
                        best_key = key;
                        best = cand[j];
                    end
                end
                m_v[m] = 1'b1;
                m_q[m] = best;
            end else begin
                m_v[m] = 1'b0;
            end
        end
        if (acc) m_last[m] = old_q;
        m_pend[m] = nxt;
        m_ovf[m]  = ov;
    endtask

    task automatic compare_all();
        check_eq("m0_v",    if0.V,    m_v[0]);
        check_eq("m0_q",    if0.Q,    m_q[0]);
        check_eq("m0_pend", if0.PEND, m_pend[0]);
        check_eq("m0_ovf",  if0.OVF,  m_ovf[0]);
        check_eq("m1_v",    if1.V,    m_v[1]);
        check_eq("m1_q",    if1.Q,    m_q[1]);
        check_eq("m1_pend", if1.PEND, m_pend[1]);
        check_eq("m1_ovf",  if1.OVF,  m_ovf[1]);
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_m0_v", if0.V, 0);    check_eq("rst_m0_q", if0.Q, 0);
        check_eq("rst_m0_pend", if0.PEND, 0); check_eq("rst_m0_ovf", if0.OVF, 0);
        check_eq("rst_m1_v", if1.V, 0);    check_eq("rst_m1_pend", if1.PEND, 0);
        model_reset();
        drv_d = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; drv_d = '0; drv_en = 1'b1; drv_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Reset while presenting with PEND=A4, then idle.
        drv_ready = 1'b0; drv_d = 8'hA4; step();
        drv_d = '0; step();
        check_eq("t1_pre_v", if0.V, 1); check_eq("t1_pre_pend", if0.PEND, 8'hA4);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_idle_v", if0.V, 0);
        end

        // Fixed priority drain of A4.
        drv_ready = 1'b1; drv_d = 8'hA4; step();
        drv_d = '0;
        step(); check_eq("t2_q7", if0.Q, 7); check_eq("t2_v", if0.V, 1);
        step(); check_eq("t2_q5", if0.Q, 5);
        step(); check_eq("t2_q2", if0.Q, 2);
        step(); check_eq("t2_done_v", if0.V, 0); check_eq("t2_done_pend", if0.PEND, 0);

        // Backpressure: no preemption by D[7].
        do_reset();
        drv_ready = 1'b0; drv_d = 8'h20; step();
        drv_d = '0; step();
        step();
        drv_d = 8'h80; step();
        drv_d = '0; step();
        check_eq("t3_hold_q", if0.Q, 5); check_eq("t3_hold_v", if0.V, 1);
        drv_ready = 1'b1;
        step(); check_eq("t3_next_q", if0.Q, 7);
        step(); check_eq("t3_end_v", if0.V, 0);

        // Round-robin sweep of FF then 81.
        do_reset();
        drv_ready = 1'b1; drv_d = 8'hFF; step();
        drv_d = '0;
        for (int i = 0; i < N; i++) begin
            step();
            check_eq("t4_rr_q", if1.Q, i);
            check_eq("t4_rr_v", if1.V, 1);
        end
        step(); check_eq("t4_rr_idle", if1.V, 0);
        drv_d = 8'h81; step();
        drv_d = '0;
        step(); check_eq("t4_81_q0", if1.Q, 0);
        step(); check_eq("t4_81_q7", if1.Q, 7);
        step();

        // Coalescing of D[4].
        do_reset();
        drv_ready = 1'b0; drv_d = 8'h10; step();
        drv_d = '0; step(); step();
        drv_d = 8'h10; step();
        check_eq("t5_ovf", if0.OVF, 1);
        drv_d = '0; step();
        check_eq("t5_ovf_clear", if0.OVF, 0);
        drv_ready = 1'b1; step();
        check_eq("t5_single_grant", if0.V, 0);
        step();

        // Accept with simultaneous re-assert, then EN gating.
        do_reset();
        drv_ready = 1'b0; drv_d = 8'h08; step();
        drv_d = '0; step();
        check_eq("t6_q3", if0.Q, 3);
        drv_ready = 1'b1; drv_d = 8'h08; step();
        check_eq("t6_no_ovf", if0.OVF, 0); check_eq("t6_pend3", if0.PEND, 8'h08);
        drv_d = '0; step();
        check_eq("t6_again_v", if0.V, 1); check_eq("t6_again_q", if0.Q, 3);
        step();
        drv_en = 1'b0; drv_d = 8'h44; step();
        drv_d = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t6_en_low_v", if0.V, 0);
        end
        drv_en = 1'b1; step();
        check_eq("t6_en_v", if0.V, 1); check_eq("t6_en_q", if0.Q, 6);

        // Random traffic with a reset in the middle.
        for (int it = 0; it < 400; it++) begin
            drv_d     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            drv_ready = ($urandom_range(0, 3) != 0);
            drv_en    = ($urandom_range(0, 7) != 0);
            if (it == 200) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
Parametrised, registered successor to the team's combinational 4:2 encoder. It captures one-cycle request events on N input lines into a pending register. Pending requests are encoded one at a time, in fixed-priority or round-robin order, and presented as a binary index with a valid/ready handshake. It sits between event sources (interrupt/status lines) and a downstream consumer that may stall.

Parameters:
N, 8, number of request lines; legal range 2..64.
QW, 3, index width; must equal clog2(N).
MODE, 0, selection order: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST_N  input  1  asynchronous, active-low reset.
D  input  N  request events; every bit is sampled every cycle.
EN  input  1  allows new indices to be loaded onto the output.
READY  input  1  consumer accepts Q this cycle when V=1.
Q  output  QW  encoded index of the presented request.
V  output  1  Q is valid.
PEND  output  N  registered pending-request vector.
OVF  output  1  one-cycle pulse: a request was coalesced into an already-pending bit.

Behaviour:
- Reset (RST_N=0, asynchronous assert): PEND=0, Q=0, V=0, OVF=0, round-robin pointer LAST=N-1. Reset mid-operation discards all pending requests and any presented index. After release, first V is no earlier than 2 edges after a D sample.
- Accept: acc = V & READY. clr = onehot(Q) when acc, else 0.
- Pending update: PEND <= (PEND & ~clr) | D. D wins over clr, so re-asserting the accepted index in the accept cycle is a new event and does not raise OVF.
- OVF <= |(D & PEND & ~clr). Coalesced events produce a single grant.
- Candidate set: C = PEND & ~clr & ~(V & ~acc ? onehot(Q) : 0). The presented bit is never re-selected.
- Load rule: when V=0 or acc=1:
  - if EN=1 and C!=0: Q <= sel(C), V <= 1;
  - otherwise V <= 0 and Q holds its value.
- While V=1 and READY=0: Q and V hold stable. EN is ignored for the held output.
- EN=0: no new loads. Pending still accumulates and the presented index may still be accepted.
- sel, MODE=0: highest set index in C.
- sel, MODE=1: first set index searching upward from LAST+1 and wrapping through N-1 to 0. LAST <= Q on every accept.
- Latency: D bit at edge k, PEND bit visible after edge k, V/Q after edge k+1 (if output free and EN=1). Back-to-back accepts with READY=1 give one index per cycle, with no bubble.
- Indices of D bits not yet in PEND are not candidates in the same cycle.
- Q is 0-based. A request on D[i] yields Q=i.

Test Plan:
1. Reset: assert RST_N=0 asynchronously while V=1 and PEND=8'hA4 -> immediately PEND=0, V=0, Q=0, OVF=0. After release, no V until D is pulsed.
2. MODE=0, EN=1, READY=1, D=8'b1010_0100 for one cycle -> V high 3 consecutive cycles with Q=7,5,2, then V=0 and PEND=0.
3. Backpressure: MODE=0, pulse D[5], hold READY=0 for 4 cycles, pulse D[7] during the stall -> Q stays 5 with V=1 (no preemption). After READY=1: Q=5 accepted, then Q=7, then V=0.
4. MODE=1, READY=1, D=8'hFF for one cycle after reset -> Q=0,1,2,...,7 on consecutive cycles. Then D=8'h81 -> Q=0 then 7.
5. Coalescing: READY=0, pulse D[4] twice, 3 cycles apart -> single OVF pulse one cycle after the second pulse. After READY=1, exactly one grant of Q=4.
6. Simultaneous accept/re-assert and EN gating: with Q=3, V=1, drive READY=1 and D[3]=1 in the same cycle -> no OVF, Q=3 is presented again next cycle. With EN=0 and PEND!=0 -> V stays 0 until EN=1, then V rises the next edge.
